dummy_scan_scheduler: RTL and testbench
=======================================

// Module: dummy_scan_scheduler
// PURPOSE
//  Decides when the dummy-scan engine runs, and shares the panel row driver between frame readout and dummy scan.
//  - Periodic requests: seconds timer against cfg_period. Manual requests: sw_request.
//  - Readout has priority. A pending dummy scan waits for an idle window, then fires one eng_trigger pulse.
//  - Sits between the frame/readout sequencer and the dummy-scan engine. Ensures they never drive rows together.
// PARAMETERS
//  TICK_CYCLES     100_000_000  clk cycles per 1 s tick (bench overrides to 10)
//  MIN_PERIOD      30           smallest cfg_period (s) that enables periodic mode
//  MAX_DEFER       4            frame grants a pending scan may lose before it takes priority
//  TIMEOUT_CYCLES  4096         max cycles from eng_trigger to eng_complete
// PORTS
//  clk             in   1   system clock; all logic on posedge
//  rst_n           in   1   reset; synchronous and active-low
//  cfg_enable      in   1   periodic mode enable
//  cfg_period      in   16  periodic interval, seconds
//  sw_request      in   1   1-cycle manual dummy-scan request
//  frame_start_req in   1   readout wants row driver (level, held until frame_grant)
//  frame_busy      in   1   readout currently owns row driver
//  frame_grant     out  1   1-cycle pulse: readout may start
//  eng_trigger     out  1   1-cycle pulse to dummy-scan engine
//  eng_complete    in   1   1-cycle done pulse from engine
//  sched_busy      out  1   dummy scan owns row driver (TRIGGER/RUN)
//  pending         out  1   dummy scan requested, not yet triggered
//  missed_count    out  8   requests dropped while already pending/running (saturating)
//  done_pulse      out  1   1-cycle: dummy scan finished OK
//  err_timeout     out  1   sticky: engine failed to complete; cleared by sw_request or reset
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state IDLE; tick/sec/defer counters 0.
//   All outputs 0 (including missed_count, err_timeout). Reset mid-scan abandons it; no trigger issued afterwards.
//  Timer: tick_cnt counts 0..TICK_CYCLES-1 and wraps. On wrap, sec_cnt+1 (saturates at 0xFFFF).
//   sec_cnt is held at 0 while cfg_enable=0 or cfg_period<MIN_PERIOD.
//  period_hit = cfg_enable && cfg_period>=MIN_PERIOD && sec_cnt>=cfg_period. sec_cnt clears the cycle after a hit.
//  Request capture, on period_hit or sw_request:
//   - IDLE: set pending next cycle.
//   - pending=1 or sched_busy=1: missed_count+1, saturating at 255.
//   - period_hit and sw_request in the same cycle count as one request.
//  sw_request is honoured regardless of cfg_enable.
//  FSM states: IDLE, WAIT_WIN, TRIGGER, RUN.
//   IDLE -> WAIT_WIN when pending sets.
//   WAIT_WIN, frame_busy=1: stay.
//   WAIT_WIN, frame_busy=0 and frame_start_req=1:
//    - defer_cnt<MAX_DEFER: grant readout (frame_grant pulse), defer_cnt+1, stay.
//    - defer_cnt>=MAX_DEFER: go to TRIGGER; readout is not granted.
//   WAIT_WIN, frame_busy=0 and frame_start_req=0: go to TRIGGER.
//   TRIGGER (1 cycle): eng_trigger=1; pending clears; defer_cnt clears; timeout counter loads 0 -> RUN.
//   RUN: eng_complete -> IDLE with done_pulse=1 next cycle.
//        timeout counter reaching TIMEOUT_CYCLES-1 -> IDLE, err_timeout=1, no done_pulse.
//  frame_grant rules:
//   - In IDLE, frame_grant pulses for frame_start_req && !frame_busy.
//   - At most one pulse per request; requester drops the request on grant.
//   - Never pulses in TRIGGER/RUN. A request arriving then waits until IDLE.
//  eng_complete outside RUN is ignored. sched_busy=1 exactly in TRIGGER and RUN.
//  Latency:
//   - sw_request at cycle N, readout idle: pending at N+1, eng_trigger at N+3.
//   - eng_complete at M: done_pulse at M+1.
// TESTING
//  1. TICK_CYCLES=10, cfg_period=30, enable=1, no frames -> eng_trigger every 300 clk +/-2. missed_count stays 0.
//  2. cfg_period=29 -> no eng_trigger in 1000 clk. sw_request -> eng_trigger 3 clk later.
//  3. Pending, frame_busy=1 for 50 clk -> no eng_trigger during busy. Trigger 1 clk after frame_busy falls.
//  4. Pending, frame_start_req held high with frame_busy pulses -> exactly 4 frame_grants, then eng_trigger, no 5th grant.
//  5. Trigger, engine silent -> err_timeout=1 after 4096 clk, state IDLE. Next sw_request clears it and retriggers.
//  6. 3 sw_requests during RUN -> missed_count=3. rst_n low mid-RUN -> all outputs 0, no later eng_trigger.

Source files
------------

// File: rtl/dummy_scan_scheduler.sv
// rtl/dummy_scan_scheduler.sv - schedules dummy scans and arbitrates the row driver against frame readout
// Periodic and manual requests queue one pending scan, which fires in the first idle readout window.
module dummy_scan_scheduler #(
  parameter int unsigned TICK_CYCLES    = 100_000_000,
  parameter int unsigned MIN_PERIOD     = 30,
  parameter int unsigned MAX_DEFER      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_enable,
  input  logic [15:0] cfg_period,
  input  logic        sw_request,
  input  logic        frame_start_req,
  input  logic        frame_busy,
  output logic        frame_grant,
  output logic        eng_trigger,
  input  logic        eng_complete,
  output logic        sched_busy,
  output logic        pending,
  output logic [7:0]  missed_count,
  output logic        done_pulse,
  output logic        err_timeout
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int DW = $clog2(MAX_DEFER + 1);
  localparam int OW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_WIN, TRIGGER, RUN} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [15:0]   sec_cnt_q, sec_cnt_d;
  logic [DW-1:0] defer_cnt_q, defer_cnt_d;
  logic [OW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          pending_q, pending_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [7:0]    missed_q, missed_d;
  logic          tick_wrap, period_ok, period_hit, req, grant_c, busy_c;

  always_comb begin
    tick_wrap  = (tick_cnt_q == TW'(TICK_CYCLES - 1));
    tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + TW'(1);
    period_ok  = cfg_enable && (cfg_period >= 16'(MIN_PERIOD));
    period_hit = period_ok && (sec_cnt_q >= cfg_period);
    sec_cnt_d  = sec_cnt_q;
    if (!period_ok || period_hit) begin
      sec_cnt_d = '0;
    end else if (tick_wrap && (sec_cnt_q != 16'hFFFF)) begin
      sec_cnt_d = sec_cnt_q + 16'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    defer_cnt_d = defer_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    pending_d   = pending_q;
    missed_d    = missed_q;
    err_d       = err_q;
    done_d      = 1'b0;
    grant_c     = 1'b0;
    eng_trigger = 1'b0;
    busy_c      = (state_q == TRIGGER) || (state_q == RUN);
    req         = period_hit || sw_request;

    if (sw_request) begin
      err_d = 1'b0;
    end
    // A simultaneous periodic hit and manual request collapse into one request.
    if (req) begin
      if (pending_q || busy_c) begin
        if (missed_q != 8'hFF) missed_d = missed_q + 8'd1;
      end else begin
        pending_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        grant_c = frame_start_req && !frame_busy;
        if (pending_q) state_d = WAIT_WIN;
      end
      WAIT_WIN: begin
        if (!frame_busy) begin
          if (frame_start_req && (defer_cnt_q < DW'(MAX_DEFER))) begin
            grant_c     = 1'b1;
            defer_cnt_d = defer_cnt_q + DW'(1);
          end else begin
            state_d = TRIGGER;
          end
        end
      end
      TRIGGER: begin
        eng_trigger = 1'b1;
        pending_d   = 1'b0;
        defer_cnt_d = '0;
        tmo_cnt_d   = '0;
        state_d     = RUN;
      end
      RUN: begin
        if (eng_complete) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (tmo_cnt_q == OW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + OW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      sec_cnt_q   <= '0;
      defer_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      pending_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      missed_q    <= '0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      sec_cnt_q   <= sec_cnt_d;
      defer_cnt_q <= defer_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      pending_q   <= pending_d;
      done_q      <= done_d;
      err_q       <= err_d;
      missed_q    <= missed_d;
    end
  end

  // Grant is combinational from the request, so hold it low while reset is asserted.
  assign frame_grant  = grant_c && rst_n;
  assign sched_busy   = busy_c;
  assign pending      = pending_q;
  assign missed_count = missed_q;
  assign done_pulse   = done_q;
  assign err_timeout  = err_q;

endmodule

// File: tb/tb_dummy_scan_scheduler.sv
// tb/tb_dummy_scan_scheduler.sv - scoreboard bench for dummy_scan_scheduler
// Stimulus pushes expected trigger/done cycles; a forked monitor pops and compares them.
module tb_dummy_scan_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_enable;
  logic [15:0] cfg_period;
  logic        sw_request;
  logic        frame_start_req;
  logic        frame_busy;
  logic        frame_grant;
  logic        eng_trigger;
  logic        eng_complete;
  logic        sched_busy;
  logic        pending;
  logic [7:0]  missed_count;
  logic        done_pulse;
  logic        err_timeout;

  typedef struct {
    int c;
    int tol;
  } exp_t;

  exp_t trig_q[$];
  exp_t done_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   trig_seen = 0;
  int   grant_cnt = 0;
  bit   engine_auto = 1'b1;

  dummy_scan_scheduler #(
    .TICK_CYCLES(10),
    .MIN_PERIOD(30),
    .MAX_DEFER(4),
    .TIMEOUT_CYCLES(4096)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_enable(cfg_enable),
    .cfg_period(cfg_period),
    .sw_request(sw_request),
    .frame_start_req(frame_start_req),
    .frame_busy(frame_busy),
    .frame_grant(frame_grant),
    .eng_trigger(eng_trigger),
    .eng_complete(eng_complete),
    .sched_busy(sched_busy),
    .pending(pending),
    .missed_count(missed_count),
    .done_pulse(done_pulse),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk_range(input string name, input int got, input int exp, input int tol);
    checks++;
    if (got < exp - tol || got > exp + tol) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d tol=%0d", name, got, exp, tol);
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    chk_range(name, got, exp, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_trig(input int c, input int tol);
    exp_t e;
    e.c = c;
    e.tol = tol;
    trig_q.push_back(e);
  endtask

  task automatic sw_pulse(input int lat);
    sw_request = 1'b1;
    if (lat > 0) expect_trig(cyc + lat, 0);
    step();
    sw_request = 1'b0;
  endtask

  task automatic wait_trig(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      step();
      if (eng_trigger) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (eng_trigger) begin
          trig_seen++;
          if (trig_q.size() == 0) begin
            chk("unexpected_trigger_cycle", cyc, -1);
          end else begin
            e = trig_q.pop_front();
            chk_range("trigger_cycle", cyc, e.c, e.tol);
          end
        end
        if (done_pulse) begin
          if (done_q.size() == 0) begin
            chk("unexpected_done_cycle", cyc, -1);
          end else begin
            e = done_q.pop_front();
            chk("done_cycle", cyc, e.c);
          end
        end
        if (frame_grant) grant_cnt++;
      end
    end
  endtask

  task automatic engine();
    exp_t e;
    forever begin
      @(negedge clk);
      if (eng_trigger && engine_auto) begin
        repeat (5) @(posedge clk);
        #1;
        eng_complete = 1'b1;
        e.c = cyc + 1;
        e.tol = 0;
        done_q.push_back(e);
        @(posedge clk);
        #1;
        eng_complete = 1'b0;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_frame_grant"}, int'(frame_grant), 0);
    chk({tag, "_eng_trigger"}, int'(eng_trigger), 0);
    chk({tag, "_sched_busy"}, int'(sched_busy), 0);
    chk({tag, "_pending"}, int'(pending), 0);
    chk({tag, "_missed_count"}, int'(missed_count), 0);
    chk({tag, "_done_pulse"}, int'(done_pulse), 0);
    chk({tag, "_err_timeout"}, int'(err_timeout), 0);
  endtask

  initial begin
    bit ok;
    int t0, base, tr;
    rst_n = 1'b0;
    cfg_enable = 1'b0;
    cfg_period = 16'd0;
    sw_request = 1'b0;
    frame_start_req = 1'b0;
    frame_busy = 1'b0;
    eng_complete = 1'b0;
    fork
      monitor();
      engine();
    join_none
    repeat (3) step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Periodic mode: 30 s at 10 clk per second
    cfg_period = 16'd30;
    cfg_enable = 1'b1;
    expect_trig(cyc + 298, 5);
    wait_trig(400, ok);
    chk("t1_first_trigger_seen", int'(ok), 1);
    t0 = cyc;
    for (int k = 0; k < 3; k++) begin
      expect_trig(t0 + 300, 2);
      wait_trig(320, ok);
      chk("t1_periodic_trigger_seen", int'(ok), 1);
      t0 = cyc;
    end
    cfg_enable = 1'b0;
    chk("t1_missed_count", int'(missed_count), 0);
    repeat (10) step();

    // Period below minimum: periodic mode stays off
    cfg_period = 16'd29;
    cfg_enable = 1'b1;
    base = trig_seen;
    repeat (1000) step();
    chk("t2_no_periodic_trigger", trig_seen - base, 0);
    sw_pulse(3);
    wait_trig(10, ok);
    chk("t2_sw_trigger_seen", int'(ok), 1);
    cfg_enable = 1'b0;
    repeat (10) step();

    // Readout busy holds off the pending scan
    frame_busy = 1'b1;
    base = trig_seen;
    sw_pulse(0);
    repeat (50) step();
    chk("t3_pending_while_busy", int'(pending), 1);
    chk("t3_no_trigger_while_busy", trig_seen - base, 0);
    frame_busy = 1'b0;
    expect_trig(cyc + 1, 0);
    wait_trig(5, ok);
    chk("t3_trigger_after_busy", int'(ok), 1);
    repeat (10) step();

    // Readout keeps requesting: four grants, then the scan wins
    frame_busy = 1'b1;
    frame_start_req = 1'b1;
    sw_pulse(0);
    repeat (3) step();
    grant_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      frame_busy = 1'b0;
      frame_start_req = 1'b1;
      if (k == 4) expect_trig(cyc + 1, 0);
      step();
      if (k < 4) begin
        frame_start_req = 1'b0;
        frame_busy = 1'b1;
        repeat (3) step();
      end
    end
    repeat (3) step();
    chk("t4_grant_count", grant_cnt, 4);
    chk("t4_sched_busy_in_run", int'(sched_busy), 1);
    frame_start_req = 1'b0;
    frame_busy = 1'b0;
    repeat (10) step();

    // Silent engine: timeout, then a new request clears the error
    engine_auto = 1'b0;
    tr = cyc + 3;
    sw_pulse(3);
    ok = 1'b0;
    for (int i = 0; i < 4300; i++) begin
      step();
      if (err_timeout) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t5_timeout_seen", int'(ok), 1);
    chk_range("t5_timeout_latency", cyc - tr, 4097, 1);
    chk("t5_idle_sched_busy", int'(sched_busy), 0);
    chk("t5_idle_pending", int'(pending), 0);
    engine_auto = 1'b1;
    sw_pulse(3);
    chk("t5_err_cleared", int'(err_timeout), 0);
    wait_trig(5, ok);
    chk("t5_retrigger_seen", int'(ok), 1);
    repeat (10) step();

    // Missed requests during RUN, then reset mid-scan
    engine_auto = 1'b0;
    sw_pulse(3);
    repeat (4) step();
    for (int k = 0; k < 3; k++) begin
      sw_pulse(0);
      step();
    end
    chk("t6_missed_count", int'(missed_count), 3);
    rst_n = 1'b0;
    step();
    chk_all_zero("t6_reset");
    rst_n = 1'b1;
    base = trig_seen;
    repeat (200) step();
    chk("t6_no_trigger_after_reset", trig_seen - base, 0);

    chk("final_trig_queue_empty", trig_q.size(), 0);
    chk("final_done_queue_empty", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
